// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

   typedef enum logic {RUN, LU_STALL} state_e;

   localparam int unsigned LU_CNT_W = 2;

   typedef struct packed {
      logic pc_write;
      logic if_id_write;
      logic bubble;
      logic flush;
      logic hold;
   } ctl_t;

   localparam ctl_t CTL_RUN = '{pc_write: 1'b1, if_id_write: 1'b1, bubble: 1'b0,
                                flush: 1'b0, hold: 1'b0};
   localparam ctl_t CTL_STALL = '{pc_write: 1'b0, if_id_write: 1'b0, bubble: 1'b1,
                                  flush: 1'b0, hold: 1'b0};
   localparam ctl_t CTL_FLUSH = '{pc_write: 1'b1, if_id_write: 1'b1, bubble: 1'b0,
                                  flush: 1'b1, hold: 1'b0};
   localparam ctl_t CTL_FREEZE = '{pc_write: 1'b0, if_id_write: 1'b0, bubble: 1'b0,
                                   flush: 1'b0, hold: 1'b1};

endpackage

// File: rtl/hazard_cmp.sv
// Load-use hit detection: compares the EX load destination against the ID sources.
module hazard_cmp
   import hazard_pkg::*;
#(
   parameter int unsigned REG_AW   = 5,
   parameter int unsigned ZERO_REG = 1
) (
   input  logic              ex_mem_read_i,
   input  logic [REG_AW-1:0] ex_rd_i,
   input  logic [REG_AW-1:0] id_rs_i,
   input  logic [REG_AW-1:0] id_rt_i,
   input  logic              id_use_rs_i,
   input  logic              id_use_rt_i,
   output logic              hit_o
);

   logic rs_match;
   logic rt_match;
   logic rd_is_zero;

   assign rs_match   = id_use_rs_i && (id_rs_i == ex_rd_i);
   assign rt_match   = id_use_rt_i && (id_rt_i == ex_rd_i);
   // A hardwired zero register can never carry a pending load result.
   assign rd_is_zero = (ZERO_REG != 0) && (ex_rd_i == '0);

   assign hit_o = ex_mem_read_i && (rs_match || rt_match) && !rd_is_zero;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use bubbles, branch flush, memory-wait freeze,
// memory timeout watchdog and stall performance counter.
module hazard_ctrl_unit
   import hazard_pkg::*;
#(
   parameter int unsigned REG_AW      = 5,
   parameter int unsigned LU_BUBBLES  = 1,
   parameter int unsigned ZERO_REG    = 1,
   parameter int unsigned MEM_TIMEOUT = 64,
   parameter int unsigned PERF_W      = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              EX_MemRead_i,
   input  logic [REG_AW-1:0] EX_Rd_i,
   input  logic [REG_AW-1:0] ID_Rs_i,
   input  logic [REG_AW-1:0] ID_Rt_i,
   input  logic              ID_UseRs_i,
   input  logic              ID_UseRt_i,
   input  logic              ID_BranchTaken_i,
   input  logic              MEM_Req_i,
   input  logic              MEM_Ready_i,
   output logic              PCWrite_o,
   output logic              IF_IDWrite_o,
   output logic              ID_EX_Bubble_o,
   output logic              IF_ID_Flush_o,
   output logic              EX_MEM_Hold_o,
   output logic              err_o,
   output logic [PERF_W-1:0] stall_cnt_o
);

   localparam logic [7:0]          TimeoutVal = 8'(MEM_TIMEOUT);
   localparam logic [LU_CNT_W-1:0] BubInit    = LU_CNT_W'(LU_BUBBLES - 1);

   logic                hit;
   logic                mwait;
   ctl_t                ctl;
   state_e              state_q;
   logic [LU_CNT_W-1:0] bub_cnt_q;
   logic [7:0]          wait_cnt_q;
   logic                err_q;
   logic [PERF_W-1:0]   stall_cnt_q;

   hazard_cmp #(
      .REG_AW   (REG_AW),
      .ZERO_REG (ZERO_REG)
   ) u_cmp (
      .ex_mem_read_i (EX_MemRead_i),
      .ex_rd_i       (EX_Rd_i),
      .id_rs_i       (ID_Rs_i),
      .id_rt_i       (ID_Rt_i),
      .id_use_rs_i   (ID_UseRs_i),
      .id_use_rt_i   (ID_UseRt_i),
      .hit_o         (hit)
   );

   assign mwait = MEM_Req_i && !MEM_Ready_i;

   // Priority: reset > memory wait > load-use > branch.
   always_comb begin
      ctl = CTL_RUN;
      if (!rst_i) begin
         ctl = CTL_STALL;
      end else if (mwait) begin
         ctl = CTL_FREEZE;
      end else if ((state_q == LU_STALL) || hit) begin
         ctl = CTL_STALL;
      end else if (ID_BranchTaken_i) begin
         ctl = CTL_FLUSH;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q     <= RUN;
         bub_cnt_q   <= '0;
         wait_cnt_q  <= '0;
         err_q       <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         if (!ctl.pc_write && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + PERF_W'(1);
         end
         if (mwait) begin
            if (wait_cnt_q != TimeoutVal) begin
               wait_cnt_q <= wait_cnt_q + 8'd1;
            end
            if (wait_cnt_q >= TimeoutVal - 8'd1) begin
               err_q <= 1'b1;
            end
         end else begin
            wait_cnt_q <= '0;
            unique case (state_q)
               RUN: begin
                  if (hit && (LU_BUBBLES > 1)) begin
                     state_q   <= LU_STALL;
                     bub_cnt_q <= BubInit;
                  end
               end
               LU_STALL: begin
                  // The load has already left EX; only the counter tracks the stall.
                  bub_cnt_q <= bub_cnt_q - LU_CNT_W'(1);
                  if (bub_cnt_q == LU_CNT_W'(1)) begin
                     state_q <= RUN;
                  end
               end
               default: state_q <= RUN;
            endcase
         end
      end
   end

   assign PCWrite_o      = ctl.pc_write;
   assign IF_IDWrite_o   = ctl.if_id_write;
   assign ID_EX_Bubble_o = ctl.bubble;
   assign IF_ID_Flush_o  = ctl.flush;
   assign EX_MEM_Hold_o  = ctl.hold;
   assign err_o          = err_q;
   assign stall_cnt_o    = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: two configurations driven in parallel, checked against
// directed vectors and a behavioural model.
module tb_hazard_ctrl_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic       mr;
   logic [4:0] rd, rs, rt;
   logic       urs, urt, br, req, rdy;
   logic [4:0] ctl_a, ctl_b;
   logic       err_a, err_b;
   logic [15:0] sc_a;
   logic [2:0]  sc_b;

   always #5 clk = ~clk;

   hazard_ctrl_unit #(
      .REG_AW      (5),
      .LU_BUBBLES  (3),
      .ZERO_REG    (1),
      .MEM_TIMEOUT (4),
      .PERF_W      (16)
   ) dut_a (
      .clk_i            (clk),
      .rst_i            (rst),
      .EX_MemRead_i     (mr),
      .EX_Rd_i          (rd),
      .ID_Rs_i          (rs),
      .ID_Rt_i          (rt),
      .ID_UseRs_i       (urs),
      .ID_UseRt_i       (urt),
      .ID_BranchTaken_i (br),
      .MEM_Req_i        (req),
      .MEM_Ready_i      (rdy),
      .PCWrite_o        (ctl_a[4]),
      .IF_IDWrite_o     (ctl_a[3]),
      .ID_EX_Bubble_o   (ctl_a[2]),
      .IF_ID_Flush_o    (ctl_a[1]),
      .EX_MEM_Hold_o    (ctl_a[0]),
      .err_o            (err_a),
      .stall_cnt_o      (sc_a)
   );

   hazard_ctrl_unit #(
      .REG_AW      (5),
      .LU_BUBBLES  (1),
      .ZERO_REG    (0),
      .MEM_TIMEOUT (64),
      .PERF_W      (3)
   ) dut_b (
      .clk_i            (clk),
      .rst_i            (rst),
      .EX_MemRead_i     (mr),
      .EX_Rd_i          (rd),
      .ID_Rs_i          (rs),
      .ID_Rt_i          (rt),
      .ID_UseRs_i       (urs),
      .ID_UseRt_i       (urt),
      .ID_BranchTaken_i (br),
      .MEM_Req_i        (req),
      .MEM_Ready_i      (rdy),
      .PCWrite_o        (ctl_b[4]),
      .IF_IDWrite_o     (ctl_b[3]),
      .ID_EX_Bubble_o   (ctl_b[2]),
      .IF_ID_Flush_o    (ctl_b[1]),
      .EX_MEM_Hold_o    (ctl_b[0]),
      .err_o            (err_b),
      .stall_cnt_o      (sc_b)
   );

   // Control bundle order: {PCWrite, IF_IDWrite, Bubble, Flush, Hold}
   localparam logic [4:0] ERun = 5'b11000, EStall = 5'b00100, EFlush = 5'b11010,
                          EFreeze = 5'b00001;

   typedef struct packed {
      logic       mr;
      logic [4:0] rd, rs, rt;
      logic       urs, urt, br, req, rdy;
      logic [4:0] ea, eb;
   } vec_t;

   vec_t tbl [14];

   int lu_c [2] = '{3, 1};
   int zr_c [2] = '{1, 0};
   int to_c [2] = '{4, 64};
   int sm_c [2] = '{65535, 7};

   // Model state: bubbles still owed, consecutive wait cycles, sticky error, stall count.
   int m_rem [2];
   int m_wait [2];
   int m_stall [2];
   bit m_err [2];

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input int exp);
      n_cmp++;
      if (act !== 32'(exp)) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit m_hit(input int k);
      return mr && ((urs && rs == rd) || (urt && rt == rd)) && !(zr_c[k] != 0 && rd == 0);
   endfunction

   function automatic logic [4:0] m_ctl(input int k);
      if (!rst) return EStall;
      if (req && !rdy) return EFreeze;
      if (m_rem[k] > 0 || m_hit(k)) return EStall;
      if (br) return EFlush;
      return ERun;
   endfunction

   task automatic m_update();
      for (int k = 0; k < 2; k++) begin
         logic [4:0] c;
         bit h;
         c = m_ctl(k);
         h = m_hit(k);
         if (!rst) begin
            m_rem[k] = 0; m_wait[k] = 0; m_err[k] = 0; m_stall[k] = 0;
         end else begin
            if (!c[4] && m_stall[k] < sm_c[k]) m_stall[k]++;
            if (req && !rdy) begin
               if (m_wait[k] < to_c[k]) m_wait[k]++;
               if (m_wait[k] == to_c[k]) m_err[k] = 1;
            end else begin
               m_wait[k] = 0;
               if (m_rem[k] > 0) m_rem[k]--;
               else if (h) m_rem[k] = lu_c[k] - 1;
            end
         end
      end
   endtask

   task automatic check_model();
      chk("model_ctl_a", ctl_a, m_ctl(0));
      chk("model_ctl_b", ctl_b, m_ctl(1));
      chk("model_err_a", err_a, m_err[0]);
      chk("model_err_b", err_b, m_err[1]);
      chk("model_cnt_a", sc_a, m_stall[0]);
      chk("model_cnt_b", sc_b, m_stall[1]);
   endtask

   task automatic advance();
      @(posedge clk);
      m_update();
      #1;
   endtask

   task automatic step();
      @(negedge clk);
      check_model();
      advance();
   endtask

   task automatic drive(input logic i_mr, input logic [4:0] i_rd, input logic [4:0] i_rs,
                        input logic [4:0] i_rt, input logic i_urs, input logic i_urt,
                        input logic i_br, input logic i_req, input logic i_rdy);
      mr = i_mr; rd = i_rd; rs = i_rs; rt = i_rt; urs = i_urs; urt = i_urt;
      br = i_br; req = i_req; rdy = i_rdy;
   endtask

   initial begin
      tbl[0]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ERun,   ERun};
      tbl[1]  = '{1'b1, 5'd7, 5'd0, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, EStall, EStall};
      tbl[2]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, EStall, ERun};
      tbl[3]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, EStall, ERun};
      tbl[4]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ERun,   ERun};
      tbl[5]  = '{1'b1, 5'd7, 5'd0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ERun,   ERun};
      tbl[6]  = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ERun,   EStall};
      tbl[7]  = '{1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, EStall, EStall};
      tbl[8]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, EStall, EFlush};
      tbl[9]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, EStall, EFlush};
      tbl[10] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, EFlush, EFlush};
      tbl[11] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, ERun,   ERun};
      tbl[12] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, EFreeze, EFreeze};
      tbl[13] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ERun,   ERun};

      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      advance();
      @(negedge clk);
      chk("reset_ctl_a", ctl_a, EStall);
      chk("reset_cnt_a", sc_a, 0);
      check_model();
      advance();
      rst = 1'b1;

      for (int i = 0; i < 14; i++) begin
         drive(tbl[i].mr, tbl[i].rd, tbl[i].rs, tbl[i].rt, tbl[i].urs, tbl[i].urt,
               tbl[i].br, tbl[i].req, tbl[i].rdy);
         @(negedge clk);
         chk($sformatf("tbl%0d_a", i), ctl_a, tbl[i].ea);
         chk($sformatf("tbl%0d_b", i), ctl_b, tbl[i].eb);
         check_model();
         advance();
      end
      chk("tbl_cnt_a", sc_a, 7);
      chk("tbl_cnt_b", sc_b, 4);

      // Memory wait in the middle of a 3-bubble load-use stall.
      drive(1, 4, 4, 0, 1, 0, 0, 0, 0);
      @(negedge clk); chk("mw_hit_a", ctl_a, EStall); check_model(); advance();
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
         @(negedge clk); chk("mw_freeze_a", ctl_a, EFreeze); check_model(); advance();
      end
      for (int i = 0; i < 2; i++) begin
         drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
         @(negedge clk); chk("mw_resume_a", ctl_a, EStall); check_model(); advance();
      end
      @(negedge clk); chk("mw_done_a", ctl_a, ERun); check_model(); advance();
      chk("mw_no_err_a", err_a, 0);

      // Timeout watchdog: four consecutive wait cycles set the sticky flag.
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
         @(negedge clk); chk("to_pre_a", err_a, 0); check_model(); advance();
      end
      chk("to_set_a", err_a, 1);
      drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
      step();
      chk("to_sticky_a", err_a, 1);

      // Reset during the stall overrides a pending memory wait and a branch.
      drive(1, 9, 0, 9, 0, 1, 0, 0, 0);
      step();
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 1, 1, 0);
      @(negedge clk);
      chk("rst_forced_a", ctl_a, EStall);
      chk("rst_forced_b", ctl_b, EStall);
      check_model();
      advance();
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("rst_run_a", ctl_a, ERun);
      chk("rst_err_a", err_a, 0);
      chk("rst_cnt_a", sc_a, 0);
      check_model();
      advance();

      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(63) != 0);
         drive(1'($urandom_range(1)), 5'($urandom_range(3)), 5'($urandom_range(3)),
               5'($urandom_range(3)), 1'($urandom_range(1)), 1'($urandom_range(1)),
               1'($urandom_range(3) == 0), 1'($urandom_range(4) == 0),
               1'($urandom_range(1)));
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Next-generation pipeline hazard controller for the 5-stage CPU. It sits between the ID stage and the PC, IF/ID, ID/EX and EX/MEM registers.
- Extends plain load-use detection with:
  - a parametrised register-address width and load-use bubble depth;
  - per-operand use qualifiers and zero-register exclusion;
  - ID-stage branch flush;
  - multi-cycle data-memory stall with a timeout watchdog;
  - a stall performance counter.

Parameters:
- REG_AW, 5, register address width.
- LU_BUBBLES, 1, bubbles inserted per load-use hazard. Legal range 1..3.
- ZERO_REG, 1, when 1 register 0 is hardwired and never causes a hazard.
- MEM_TIMEOUT, 64, consecutive memory-wait cycles before err_o sets. Legal range 2..255.
- PERF_W, 16, width of the stall performance counter.

Ports:
- clk_i, in, 1, clock (rising edge).
- rst_i, in, 1, synchronous active-low reset.
- EX_MemRead_i, in, 1, instruction in EX is a load.
- EX_Rd_i, in, REG_AW, load destination register in EX.
- ID_Rs_i, in, REG_AW, first source register in ID.
- ID_Rt_i, in, REG_AW, second source register in ID.
- ID_UseRs_i, in, 1, ID instruction really reads Rs.
- ID_UseRt_i, in, 1, ID instruction really reads Rt.
- ID_BranchTaken_i, in, 1, branch resolved taken in ID.
- MEM_Req_i, in, 1, MEM stage has an access outstanding.
- MEM_Ready_i, in, 1, data memory completes the access this cycle.
- PCWrite_o, out, 1, PC update enable.
- IF_IDWrite_o, out, 1, IF/ID register write enable.
- ID_EX_Bubble_o, out, 1, zero the control fields into ID/EX.
- IF_ID_Flush_o, out, 1, clear IF/ID (taken branch).
- EX_MEM_Hold_o, out, 1, freeze the ID/EX, EX/MEM and MEM/WB registers.
- err_o, out, 1, sticky memory-timeout flag.
- stall_cnt_o, out, PERF_W, count of stalled cycles; saturates at all-ones.

Behaviour:
- Signal definitions:
  - hit = EX_MemRead_i && ((ID_UseRs_i && ID_Rs_i==EX_Rd_i) || (ID_UseRt_i && ID_Rt_i==EX_Rd_i)) && !(ZERO_REG && EX_Rd_i==0).
  - mwait = MEM_Req_i && !MEM_Ready_i.
- Reset (rst_i=0 at a clock edge):
  - state=RUN, bub_cnt=0, wait_cnt=0, err_o=0, stall_cnt_o=0.
  - While rst_i=0 the outputs are forced to PCWrite_o=0, IF_IDWrite_o=0, ID_EX_Bubble_o=1, IF_ID_Flush_o=0, EX_MEM_Hold_o=0.
  - Reset mid-stall abandons the stall immediately.
- Outputs are combinational from state and inputs. Priority: mwait > load-use > branch.
- mwait=1, in any state:
  - PCWrite_o=0, IF_IDWrite_o=0, EX_MEM_Hold_o=1, ID_EX_Bubble_o=0, IF_ID_Flush_o=0.
  - state and bub_cnt are frozen.
  - wait_cnt increments, saturating at MEM_TIMEOUT. When it reaches MEM_TIMEOUT, err_o sets and stays set until reset.
  - When mwait=0, wait_cnt clears to 0.
- State RUN:
  - hit=1: PCWrite_o=0, IF_IDWrite_o=0, ID_EX_Bubble_o=1, IF_ID_Flush_o=0 (a taken branch is suppressed because its operands depend on the load).
    - If LU_BUBBLES>1: next state is LU_STALL with bub_cnt=LU_BUBBLES-1.
    - Otherwise the state stays RUN.
  - hit=0 and ID_BranchTaken_i=1: PCWrite_o=1, IF_IDWrite_o=1, IF_ID_Flush_o=1, ID_EX_Bubble_o=0.
  - Otherwise: PCWrite_o=1, IF_IDWrite_o=1, all other outputs 0.
- State LU_STALL:
  - Outputs are the same as for a hit: PCWrite_o=0, IF_IDWrite_o=0, ID_EX_Bubble_o=1, regardless of hit.
  - bub_cnt decrements each non-mwait cycle. When bub_cnt==1, next state is RUN.
  - ID_BranchTaken_i is ignored.
- Latency:
  - A load-use hazard costs exactly LU_BUBBLES cycles, plus any mwait cycles.
  - A branch flush costs 1 cycle.
- stall_cnt_o increments on every cycle where PCWrite_o=0 and rst_i=1.
- EX_Rd_i of the load is not latched. The load has left EX after the first bubble, so LU_STALL relies only on the counter.

Decomposition:
- Shared package hazard_pkg holds:
  - the state enum {RUN, LU_STALL};
  - the localparam LU_CNT_W = 2;
  - the output-bundle struct (PCWrite, IF_IDWrite, Bubble, Flush, Hold) with the constants CTL_RUN, CTL_STALL, CTL_FLUSH and CTL_FREEZE.
- One sub-module, hazard_cmp: the pure combinational hit computation (with the ZERO_REG and use qualifiers), parametrised by REG_AW.

Test Plan:
- LU_BUBBLES=1, load EX_Rd=5, then ID Rs=5 UseRs=1 -> one cycle with PCWrite=0, IF_IDWrite=0, Bubble=1; next cycle RUN; stall_cnt_o=1.
- LU_BUBBLES=3, load EX_Rd=7 with ID Rt=7 UseRt=1 -> 3 consecutive bubble cycles, then PCWrite=1; same case with UseRt=0 -> no stall.
- ZERO_REG=1, load EX_Rd=0, ID Rs=0 -> no stall. ZERO_REG=0 -> 1 bubble.
- Load-use hit together with ID_BranchTaken_i=1 -> Flush=0, Bubble=1. The branch alone on the next RUN cycle -> Flush=1, PCWrite=1.
- MEM_Req=1 held with MEM_Ready=0 for 3 cycles during LU_STALL with bub_cnt=2 -> Hold=1, Bubble=0 for 3 cycles, then 2 bubbles resume. With MEM_TIMEOUT=4, 4 wait cycles -> err_o=1, sticky after MEM_Ready=1.
- rst_i=0 asserted during the second cycle of LU_STALL -> next edge state=RUN; err_o=0 and stall_cnt_o=0; forced outputs PCWrite=0, Bubble=1 while rst_i=0.
